// File: rtl/mcs6530_bus_pkg.sv
// Shared types and constants for the mcs6530 bus master and its address encoder.
package mcs6530_bus_pkg;

  typedef enum logic [1:0] {
    REG_ROM   = 2'd0,
    REG_RAM   = 2'd1,
    REG_IO    = 2'd2,
    REG_TIMER = 2'd3
  } region_t;

  typedef enum logic [1:0] {
    ERR_OK      = 2'd0,
    ERR_TIMEOUT = 2'd1,
    ERR_ROM_WR  = 2'd2
  } err_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  // A[9:6] bases for the 6530-003 RAM and I/O-timer windows
  localparam logic [3:0] RAM_BASE = 4'b1110;
  localparam logic [3:0] IOT_BASE = 4'b1100;

endpackage

// File: rtl/mcs6530_addr_encode.sv
// Maps a region + offset onto the 6530-003 pin encoding (A, RS0, CS1).
module mcs6530_addr_encode
  import mcs6530_bus_pkg::*;
(
  input  region_t     region,
  input  logic [9:0]  offset,
  output logic [9:0]  a,
  output logic        rs0,
  output logic        cs1
);

  // Region decode; offset bits outside each window are dropped
  always_comb begin
    a   = 10'h000;
    rs0 = 1'b1;
    cs1 = 1'b1;
    case (region)
      REG_ROM: begin
        a   = offset;
        rs0 = 1'b0;
        cs1 = 1'b1;
      end
      REG_RAM: begin
        a   = {RAM_BASE, offset[5:0]};
        rs0 = 1'b1;
        cs1 = 1'b0;
      end
      REG_IO: begin
        a   = {IOT_BASE, 3'b000, 1'b0, offset[1:0]};
        rs0 = 1'b1;
        cs1 = 1'b0;
      end
      REG_TIMER: begin
        a   = {IOT_BASE, 2'b00, offset[2], 1'b1, offset[1:0]};
        rs0 = 1'b1;
        cs1 = 1'b0;
      end
      default: begin
        a   = 10'h000;
        rs0 = 1'b1;
        cs1 = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/mcs6530_bus_master.sv
// Single-outstanding bus initiator driving the mcs6530 pins from a
// valid/ready command channel and returning a valid/ready response.
module mcs6530_bus_master
  import mcs6530_bus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 4,
  parameter int TMO_W          = 8
) (
  input  logic        phi2,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [1:0]  cmd_region,
  input  logic [9:0]  cmd_offset,
  input  logic [7:0]  cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [7:0]  rsp_rdata,
  output logic [1:0]  rsp_err,
  output logic [9:0]  bus_a,
  output logic [7:0]  bus_wdata,
  output logic        bus_we_n,
  output logic        bus_rs0,
  output logic        bus_cs1,
  input  logic [7:0]  bus_rdata,
  input  logic        bus_oe
);

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  state_t           state_r;
  logic             we_r;
  logic [TMO_W-1:0] tmo_cnt_r;
  region_t          region_s;
  logic [9:0]       enc_a_s;
  logic             enc_rs0_s;
  logic             enc_cs1_s;

  assign region_s = region_t'(cmd_region);

  mcs6530_addr_encode u_enc (
    .region (region_s),
    .offset (cmd_offset),
    .a      (enc_a_s),
    .rs0    (enc_rs0_s),
    .cs1    (enc_cs1_s)
  );

  // Transaction FSM; every pin and response field is registered here
  always_ff @(posedge phi2) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      we_r      <= 1'b0;
      tmo_cnt_r <= '0;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 8'h00;
      rsp_err   <= ERR_OK;
      bus_a     <= 10'h000;
      bus_wdata <= 8'h00;
      bus_we_n  <= 1'b1;
      bus_rs0   <= 1'b1;
      bus_cs1   <= 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            we_r      <= cmd_we;
            if (cmd_we && (region_s == REG_ROM)) begin
              // ROM is read-only: answer at once without touching the bus
              state_r   <= ST_RESP;
              rsp_valid <= 1'b1;
              rsp_rdata <= 8'h00;
              rsp_err   <= ERR_ROM_WR;
            end else begin
              state_r   <= ST_ACCESS;
              bus_a     <= enc_a_s;
              bus_rs0   <= enc_rs0_s;
              bus_cs1   <= enc_cs1_s;
              bus_we_n  <= ~cmd_we;
              bus_wdata <= cmd_we ? cmd_wdata : 8'h00;
            end
          end
        end
        ST_ACCESS: begin
          if (we_r) begin
            // Responder captures the write on this closing edge
            state_r   <= ST_RESP;
            rsp_valid <= 1'b1;
            rsp_rdata <= 8'h00;
            rsp_err   <= ERR_OK;
            bus_a     <= 10'h000;
            bus_wdata <= 8'h00;
            bus_we_n  <= 1'b1;
            bus_rs0   <= 1'b1;
            bus_cs1   <= 1'b1;
          end else begin
            state_r   <= ST_WAIT;
            tmo_cnt_r <= '0;
          end
        end
        ST_WAIT: begin
          if (bus_oe || (tmo_cnt_r == TMO_LAST)) begin
            // Data arriving on the last allowed cycle still wins
            state_r   <= ST_RESP;
            rsp_valid <= 1'b1;
            rsp_rdata <= bus_oe ? bus_rdata : 8'h00;
            rsp_err   <= bus_oe ? ERR_OK : ERR_TIMEOUT;
            bus_a     <= 10'h000;
            bus_wdata <= 8'h00;
            bus_we_n  <= 1'b1;
            bus_rs0   <= 1'b1;
            bus_cs1   <= 1'b1;
          end else begin
            tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state_r   <= ST_IDLE;
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
          end else begin
            rsp_valid <= 1'b1;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          cmd_ready <= 1'b0;
          rsp_valid <= 1'b0;
          bus_a     <= 10'h000;
          bus_wdata <= 8'h00;
          bus_we_n  <= 1'b1;
          bus_rs0   <= 1'b1;
          bus_cs1   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mcs6530_bus_master.sv
// Directed bench for mcs6530_bus_master with a small behavioural responder.
module tb_mcs6530_bus_master;

  logic       phi2 = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_we = 1'b0;
  logic [1:0] cmd_region = 2'd0;
  logic [9:0] cmd_offset = 10'h000;
  logic [7:0] cmd_wdata = 8'h00;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [7:0] rsp_rdata;
  logic [1:0] rsp_err;
  logic [9:0] bus_a;
  logic [7:0] bus_wdata;
  logic       bus_we_n;
  logic       bus_rs0;
  logic       bus_cs1;
  logic [7:0] bus_rdata;
  logic       bus_oe;

  logic       oe_en = 1'b1;
  logic       oe_force = 1'b0;
  logic [7:0] ram [64];

  int checks = 0;
  int failures = 0;

  always #5 phi2 = ~phi2;

  mcs6530_bus_master #(.TIMEOUT_CYCLES(4), .TMO_W(8)) dut (
    .phi2(phi2), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_region(cmd_region), .cmd_offset(cmd_offset), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .bus_a(bus_a), .bus_wdata(bus_wdata), .bus_we_n(bus_we_n),
    .bus_rs0(bus_rs0), .bus_cs1(bus_cs1), .bus_rdata(bus_rdata), .bus_oe(bus_oe)
  );

  // Responder model: RAM window backed by an array, everything else reads 0x3C
  wire sel_s = !bus_rs0 || !bus_cs1;
  wire ram_hit_s = !bus_cs1 && (bus_a[9:6] == 4'b1110);
  assign bus_rdata = ram_hit_s ? ram[bus_a[5:0]] : 8'h3C;
  assign bus_oe = oe_force | (oe_en & sel_s & bus_we_n);

  // Responder write capture
  always @(posedge phi2) begin
    if (!bus_we_n && ram_hit_s) ram[bus_a[5:0]] <= bus_wdata;
  end

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       we;
    logic [1:0] region;
    logic [9:0] offset;
    logic [7:0] wdata;
    logic       oe;
    logic [9:0] exp_a;
    logic       exp_rs0;
    logic       exp_cs1;
    logic       exp_we_n;
    logic [7:0] exp_rdata;
    logic [1:0] exp_err;
    int         exp_lat;
    int         hold;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge phi2);
    #1;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int n;
    int lat;
    cmd_we = v.we; cmd_region = v.region; cmd_offset = v.offset; cmd_wdata = v.wdata;
    oe_en = v.oe; cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 50) begin tick(); n++; end
    check($sformatf("v%0d_cmd_ready", idx), 32'(cmd_ready), 32'd1);
    tick();
    cmd_valid = 1'b0;
    lat = 1;
    check($sformatf("v%0d_bus_a", idx), 32'(bus_a), 32'(v.exp_a));
    check($sformatf("v%0d_rs0", idx), 32'(bus_rs0), 32'(v.exp_rs0));
    check($sformatf("v%0d_cs1", idx), 32'(bus_cs1), 32'(v.exp_cs1));
    check($sformatf("v%0d_we_n", idx), 32'(bus_we_n), 32'(v.exp_we_n));
    if (v.we && v.region != 2'd0)
      check($sformatf("v%0d_wdata", idx), 32'(bus_wdata), 32'(v.wdata));
    while (!rsp_valid && lat < 20) begin tick(); lat++; end
    check($sformatf("v%0d_latency", idx), 32'(lat), 32'(v.exp_lat));
    check($sformatf("v%0d_rdata", idx), 32'(rsp_rdata), 32'(v.exp_rdata));
    check($sformatf("v%0d_err", idx), 32'(rsp_err), 32'(v.exp_err));
    check($sformatf("v%0d_deselect", idx), {29'd0, bus_rs0, bus_cs1, bus_we_n}, 32'd7);
    for (int h = 0; h < v.hold; h++) begin
      tick();
      check($sformatf("v%0d_hold%0d", idx, h), {22'd0, rsp_valid, rsp_err, rsp_rdata}, {22'd0, 1'b1, v.exp_err, v.exp_rdata});
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check($sformatf("v%0d_rsp_drop", idx), 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    int n;
    int lat;
    logic seen;
    for (int i = 0; i < 64; i++) ram[i] = 8'h00;

    //          we    reg    offset   wdata  oe    exp_a    rs0   cs1   we_n  rdata  err   lat hold
    vecs[0]  = '{1'b1, 2'd1, 10'h015, 8'hA5, 1'b1, 10'h395, 1'b1, 1'b0, 1'b0, 8'h00, 2'd0, 2, 0};
    vecs[1]  = '{1'b0, 2'd1, 10'h015, 8'h00, 1'b1, 10'h395, 1'b1, 1'b0, 1'b1, 8'hA5, 2'd0, 3, 0};
    vecs[2]  = '{1'b1, 2'd0, 10'h200, 8'h77, 1'b1, 10'h000, 1'b1, 1'b1, 1'b1, 8'h00, 2'd2, 1, 0};
    vecs[3]  = '{1'b1, 2'd3, 10'h005, 8'h10, 1'b1, 10'h30D, 1'b1, 1'b0, 1'b0, 8'h00, 2'd0, 2, 0};
    vecs[4]  = '{1'b0, 2'd2, 10'h002, 8'h00, 1'b1, 10'h302, 1'b1, 1'b0, 1'b1, 8'h3C, 2'd0, 3, 0};
    vecs[5]  = '{1'b0, 2'd0, 10'h123, 8'h00, 1'b1, 10'h123, 1'b0, 1'b1, 1'b1, 8'h3C, 2'd0, 3, 0};
    vecs[6]  = '{1'b1, 2'd1, 10'h03F, 8'h5A, 1'b1, 10'h3BF, 1'b1, 1'b0, 1'b0, 8'h00, 2'd0, 2, 0};
    vecs[7]  = '{1'b0, 2'd1, 10'h0FF, 8'h00, 1'b1, 10'h3BF, 1'b1, 1'b0, 1'b1, 8'h5A, 2'd0, 3, 0};
    vecs[8]  = '{1'b0, 2'd3, 10'h3FA, 8'h00, 1'b1, 10'h306, 1'b1, 1'b0, 1'b1, 8'h3C, 2'd0, 3, 0};
    vecs[9]  = '{1'b1, 2'd2, 10'h3FF, 8'h99, 1'b1, 10'h303, 1'b1, 1'b0, 1'b0, 8'h00, 2'd0, 2, 0};
    vecs[10] = '{1'b0, 2'd1, 10'h000, 8'h00, 1'b0, 10'h380, 1'b1, 1'b0, 1'b1, 8'h00, 2'd1, 6, 3};

    // Reset state
    rst = 1'b1;
    repeat (3) tick();
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst_rsp", {22'd0, rsp_valid, rsp_err, rsp_rdata}, 32'd0);
    check("rst_bus_ctl", {29'd0, bus_rs0, bus_cs1, bus_we_n}, 32'd7);
    check("rst_bus_data", {14'd0, bus_a, bus_wdata}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 11; i++) run_vec(i, vecs[i]);

    // bus_oe arriving exactly on the timeout cycle: data wins
    oe_en = 1'b0; oe_force = 1'b0;
    cmd_we = 1'b0; cmd_region = 2'd1; cmd_offset = 10'h015; cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 50) begin tick(); n++; end
    tick();
    cmd_valid = 1'b0;
    lat = 1;
    while (lat < 5) begin tick(); lat++; end
    check("late_oe_not_yet", 32'(rsp_valid), 32'd0);
    oe_force = 1'b1;
    tick();
    oe_force = 1'b0;
    check("late_oe_valid", 32'(rsp_valid), 32'd1);
    check("late_oe_err", 32'(rsp_err), 32'd0);
    check("late_oe_rdata", 32'(rsp_rdata), 32'hA5);
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;

    // cmd_valid held while busy is not accepted again until IDLE
    oe_en = 1'b1;
    cmd_we = 1'b0; cmd_region = 2'd1; cmd_offset = 10'h015; cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 50) begin tick(); n++; end
    tick();
    seen = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      if (cmd_ready) seen = 1'b1;
      tick(); lat++;
    end
    if (cmd_ready) seen = 1'b1;
    check("busy_cmd_ready_low", 32'(seen), 32'd0);
    check("busy_rdata", 32'(rsp_rdata), 32'hA5);
    cmd_valid = 1'b0;
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
    check("busy_back_idle", 32'(cmd_ready), 32'd1);

    // Reset during WAIT drops the transaction
    oe_en = 1'b0;
    cmd_we = 1'b0; cmd_region = 2'd1; cmd_offset = 10'h015; cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 50) begin tick(); n++; end
    tick();
    cmd_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("mid_rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("mid_rst_bus_ctl", {29'd0, bus_rs0, bus_cs1, bus_we_n}, 32'd7);
    check("mid_rst_bus_a", 32'(bus_a), 32'd0);
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (rsp_valid) seen = 1'b1;
    end
    check("mid_rst_no_rsp", 32'(seen), 32'd0);
    run_vec(11, vecs[1]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
